// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and mem_system.
// slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              hit;
    logic              err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stall;
    logic              mem_hit;
    logic              mem_err;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_done, mem_stall, mem_hit, mem_err,
        output i_done, i_rdata, d_done, d_rdata, hit, err,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_done, mem_stall, mem_hit, mem_err,
        input  i_done, i_rdata, d_done, d_rdata, hit, err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one mem_system, with watchdog.
// MEM_ARB_RR_EN: round-robin on ties; undefined gives D fixed priority.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = '1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              hit_q, hit_d;
    logic              err_q, err_d;
    logic              pick_d;
    logic              resp;
    logic              unused_stall;

`ifdef MEM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    assign unused_stall = bus.mem_stall;

    // Next-state, operand latching and watchdog timing.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        timer_d = timer_q;
        rdata_d = rdata_q;
        hit_d   = hit_q;
        err_d   = err_q;
        pick_d  = bus.d_req;
`ifdef MEM_ARB_RR_EN
        last_d  = last_q;
        if (bus.i_req && bus.d_req) begin
            pick_d = ~last_q;
        end
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    owner_d = pick_d;
`ifdef MEM_ARB_RR_EN
                    last_d  = pick_d;
`endif
                    addr_d  = pick_d ? bus.d_addr : bus.i_addr;
                    wdata_d = pick_d ? bus.d_wdata : wdata_q;
                    wr_d    = pick_d & bus.d_wr;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q != T_MAX) begin
                    timer_d = timer_q + TW'(1);
                end
                if (bus.mem_done) begin
                    rdata_d = bus.mem_rdata;
                    hit_d   = bus.mem_hit;
                    err_d   = bus.mem_err;
                    state_d = S_RESP;
                end else if (TIMEOUT != 0 && timer_q == T_LAST) begin
                    rdata_d = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction state; reset drops any in-flight access without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b1;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            timer_q <= '0;
            rdata_q <= '0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            timer_q <= timer_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last granted port, 0 = fetch; starts at fetch so D wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign resp          = (state_q == S_RESP);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_rd    = (state_q == S_ISSUE) & ~wr_q;
    assign bus.mem_wr    = (state_q == S_ISSUE) & wr_q;
    assign bus.i_done    = resp & ~owner_q;
    assign bus.d_done    = resp & owner_q;
    assign bus.i_rdata   = bus.i_done ? rdata_q : '0;
    assign bus.d_rdata   = bus.d_done ? rdata_q : '0;
    assign bus.hit       = resp & hit_q;
    assign bus.err       = resp & err_q;
endmodule
